// File: rtl/seed_cache_tag_ctrl_if.sv
// Bus bundle for the seed cache: lookup/response, seed-generator refill,
// init-sequencer clear stream and the statistics counters.
interface seed_cache_tag_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int SEED_W  = 32
);
  logic               lk_valid;
  logic               lk_ready;
  logic [ADDR_W-1:0]  lk_addr;
  logic               rsp_valid;
  logic               rsp_hit;
  logic [SEED_W-1:0]  rsp_seed;
  logic               gen_req;
  logic [ADDR_W-1:0]  gen_addr;
  logic               gen_ack;
  logic [SEED_W-1:0]  gen_seed;
  logic               init_active;
  logic [INDEX_W-1:0] init_addr;
  logic [15:0]        hit_cnt;
  logic [15:0]        miss_cnt;

  // master: datapath, seed generator and init sequencer taken together
  modport master (
    output lk_valid, lk_addr, gen_ack, gen_seed, init_active, init_addr,
    input  lk_ready, rsp_valid, rsp_hit, rsp_seed, gen_req, gen_addr, hit_cnt, miss_cnt
  );

  modport slave (
    input  lk_valid, lk_addr, gen_ack, gen_seed, init_active, init_addr,
    output lk_ready, rsp_valid, rsp_hit, rsp_seed, gen_req, gen_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/seed_cache_tag_ctrl.sv
// Direct-mapped seed cache tag controller with req/ack refill and init-driven invalidation.
// Optional hit/miss statistics counters are built when SEED_CACHE_STATS_EN is defined.
module seed_cache_tag_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int LS      = 2,
  parameter int INDEX_W = 4,
  parameter int SEED_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  seed_cache_tag_ctrl_if.slave bus
);
  localparam int TAG_W   = ADDR_W - LS - INDEX_W;
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-LS){1'b1}}, {LS{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_e;

  state_e              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic                rd_vld_q, rd_vld_d;
  logic                stale_q, stale_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [SEED_W-1:0]   rsp_seed_q, rsp_seed_d;
  logic                gen_req_q, gen_req_d;
  logic [ADDR_W-1:0]   gen_addr_q, gen_addr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [TAG_W-1:0]    tag_mem  [ENTRIES];
  logic [SEED_W-1:0]   seed_mem [ENTRIES];
  logic [TAG_W-1:0]    rd_tag_q;
  logic [SEED_W-1:0]   rd_seed_q;

  logic                accept;
  logic                wr_en;
  logic                tag_match;
  logic [INDEX_W-1:0]  lk_idx;
  logic [INDEX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]    cur_tag;

  assign lk_idx       = bus.lk_addr[LS+INDEX_W-1:LS];
  assign cur_idx      = addr_q[LS+INDEX_W-1:LS];
  assign cur_tag      = addr_q[ADDR_W-1:LS+INDEX_W];
  assign bus.lk_ready = (state_q == IDLE) && !bus.init_active;
  assign accept       = bus.lk_valid && bus.lk_ready;
  assign tag_match    = rd_vld_q && (rd_tag_q == cur_tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    rd_vld_d    = rd_vld_q;
    stale_d     = stale_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = rsp_hit_q;
    rsp_seed_d  = rsp_seed_q;
    gen_req_d   = gen_req_q;
    gen_addr_d  = gen_addr_q;
    wr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = bus.lk_addr;
          rd_vld_d = valid_q[lk_idx];
          stale_d  = 1'b0;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.init_active) stale_d = 1'b1;
        // A clear in flight may have hit this entry after it was read, so never serve it.
        if (tag_match && !bus.init_active) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_seed_d  = rd_seed_q;
          state_d     = IDLE;
        end else begin
          gen_req_d  = 1'b1;
          gen_addr_d = addr_q & LINE_MASK;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (bus.init_active) stale_d = 1'b1;
        if (bus.gen_ack) begin
          wr_en       = !(stale_q || bus.init_active);
          gen_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_seed_d  = bus.gen_seed;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear is applied after the fill so it wins on an index collision.
    if (wr_en)           valid_d[cur_idx]       = 1'b1;
    if (bus.init_active) valid_d[bus.init_addr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      rd_vld_q    <= 1'b0;
      stale_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_seed_q  <= '0;
      gen_req_q   <= 1'b0;
      gen_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rd_vld_q    <= rd_vld_d;
      stale_q     <= stale_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_seed_q  <= rsp_seed_d;
      gen_req_q   <= gen_req_d;
      gen_addr_q  <= gen_addr_d;
    end
  end

  // Tag/seed storage and registered read: plain RAM, no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (accept) begin
      rd_tag_q  <= tag_mem[lk_idx];
      rd_seed_q <= seed_mem[lk_idx];
    end
    if (wr_en) begin
      tag_mem[cur_idx]  <= cur_tag;
      seed_mem[cur_idx] <= bus.gen_seed;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_seed  = rsp_seed_q;
  assign bus.gen_req   = gen_req_q;
  assign bus.gen_addr  = gen_addr_q;

`ifdef SEED_CACHE_STATS_EN
  logic        init_prev_q;
  logic        init_rise;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  assign init_rise = bus.init_active && !init_prev_q;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (init_rise) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (rsp_valid_q) begin
      if (rsp_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_prev_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      init_prev_q <= bus.init_active;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_seed_cache_tag_ctrl.sv
// Self-checking bench for seed_cache_tag_ctrl: directed vector table, hand-written
// invalidation/reset sequences and randomized lookups against a cache model.
module tb_seed_cache_tag_ctrl;
  localparam int ADDR_W = 32, LS = 2, INDEX_W = 4, SEED_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seed_cache_tag_ctrl_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .SEED_W(SEED_W)) bus ();

  seed_cache_tag_ctrl #(.ADDR_W(ADDR_W), .LS(LS), .INDEX_W(INDEX_W), .SEED_W(SEED_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Cache model: what each entry should hold, plus expected statistics.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_seed  [16];
  int          m_hits, m_misses;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] seed;
    int          ack_dly;
    bit          exp_hit;
    logic [31:0] exp_seed;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic logic [25:0] tag_of(input logic [31:0] a);
    return a[31:6];
  endfunction

  function automatic logic [15:0] exp_cnt(input int v);
`ifdef SEED_CACHE_STATS_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return 16'(v - v);
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic m_update(input logic [31:0] a, input logic [31:0] seed, input bit eh,
                          input bit any_init, input logic [3:0] init_idx);
    if (any_init) begin
      m_valid[init_idx] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
    end
    if (eh) m_hits++;
    else begin
      m_misses++;
      if (!any_init) begin
        m_valid[idx_of(a)] = 1'b1;
        m_tag[idx_of(a)]   = tag_of(a);
        m_seed[idx_of(a)]  = seed;
      end
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, " hit_cnt"},  32'(bus.hit_cnt),  32'(exp_cnt(m_hits)));
    chk({nm, " miss_cnt"}, 32'(bus.miss_cnt), 32'(exp_cnt(m_misses)));
  endtask

  // Starts and ends #1 after a rising edge.
  task automatic do_lookup(input string nm, input logic [31:0] a, input logic [31:0] seed,
                           input int ack_dly, input int init_cyc, input logic [3:0] init_idx,
                           input bit init_lk, input bit exp_hit, input logic [31:0] exp_seed);
    int n;
    bus.lk_addr  = a;
    bus.lk_valid = 1'b1;
    #1;
    n = 0;
    while (bus.lk_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk({nm, " lk_ready"}, 32'(bus.lk_ready), 32'd1);
      bus.lk_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.lk_valid = 1'b0;
    if (init_lk) begin
      bus.init_active = 1'b1;
      bus.init_addr   = init_idx;
    end
    @(posedge clk); #1;
    bus.init_active = 1'b0;
    chk({nm, " T+2 rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_hit));
    chk({nm, " T+2 gen_req"},   32'(bus.gen_req),   32'(!exp_hit));
    if (bus.rsp_valid === 1'b1) begin
      chk({nm, " rsp_hit"},  32'(bus.rsp_hit), 32'd1);
      chk({nm, " rsp_seed"}, bus.rsp_seed, exp_seed);
    end else if (bus.gen_req === 1'b1) begin
      chk({nm, " gen_addr"}, bus.gen_addr, a & 32'hFFFF_FFFC);
      for (int k = 0; k < ack_dly; k++) begin
        if (k < init_cyc) begin
          bus.init_active = 1'b1;
          bus.init_addr   = init_idx;
        end
        @(posedge clk); #1;
        bus.init_active = 1'b0;
        chk({nm, " req hold"}, 32'({bus.gen_req, bus.rsp_valid}), 32'd2);
      end
      bus.gen_ack  = 1'b1;
      bus.gen_seed = seed;
      @(posedge clk); #1;
      bus.gen_ack  = 1'b0;
      bus.gen_seed = $urandom;
      chk({nm, " refill rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, " refill rsp_hit"},   32'(bus.rsp_hit),   32'd0);
      chk({nm, " refill rsp_seed"},  bus.rsp_seed,       exp_seed);
      chk({nm, " refill gen_req"},   32'(bus.gen_req),   32'd0);
    end
    @(posedge clk); #1;
    chk({nm, " pulse end"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic run_lookup(input string nm, input logic [31:0] a, input logic [31:0] seed,
                            input int ack_dly, input int init_cyc, input logic [3:0] init_idx,
                            input bit init_lk);
    bit          eh;
    bit          any_init;
    logic [31:0] es;
    eh       = m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a)) && !init_lk;
    es       = eh ? m_seed[idx_of(a)] : seed;
    any_init = init_lk || (!eh && init_cyc > 0 && ack_dly > 0);
    do_lookup(nm, a, seed, ack_dly, init_cyc, init_idx, init_lk, eh, es);
    m_update(a, seed, eh, any_init, init_idx);
    chk_cnt(nm);
  endtask

  task automatic init_pulse(input string nm, input logic [3:0] idx);
    bus.init_active = 1'b1;
    bus.init_addr   = idx;
    #1;
    chk({nm, " lk_ready low"}, 32'(bus.lk_ready), 32'd0);
    @(posedge clk); #1;
    bus.init_active = 1'b0;
    m_valid[idx] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    #1;
    chk_cnt(nm);
  endtask

  task automatic init_sweep();
    bus.init_active = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.init_addr = 4'(15 - k);
      #1;
      chk($sformatf("sweep%0d lk_ready", k), 32'(bus.lk_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.init_active = 1'b0;
    m_reset();
    #1;
    chk("sweep done lk_ready", 32'(bus.lk_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.lk_valid    = 1'b0;
    bus.lk_addr     = '0;
    bus.gen_ack     = 1'b0;
    bus.gen_seed    = '0;
    bus.init_active = 1'b0;
    bus.init_addr   = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset lk_ready",  32'(bus.lk_ready),  32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_hit",   32'(bus.rsp_hit),   32'd0);
    chk("reset rsp_seed",  bus.rsp_seed,       32'd0);
    chk("reset gen_req",   32'(bus.gen_req),   32'd0);
    chk("reset gen_addr",  bus.gen_addr,       32'd0);
    chk("reset hit_cnt",   32'(bus.hit_cnt),   32'd0);
    chk("reset miss_cnt",  32'(bus.miss_cnt),  32'd0);

    vecs[0] = '{32'h0000_1004, 32'hA5A5_A5A5, 2, 1'b0, 32'hA5A5_A5A5};
    vecs[1] = '{32'h0000_1004, 32'hFFFF_FFFF, 0, 1'b1, 32'hA5A5_A5A5};
    vecs[2] = '{32'h0000_2004, 32'h1234_5678, 1, 1'b0, 32'h1234_5678};
    vecs[3] = '{32'h0000_1004, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D};
    vecs[4] = '{32'h0000_1007, 32'h0000_0000, 0, 1'b1, 32'h0BAD_F00D};
    vecs[5] = '{32'h0000_2004, 32'hCAFE_0002, 3, 1'b0, 32'hCAFE_0002};
    vecs[6] = '{32'h0000_1008, 32'h2222_2222, 0, 1'b0, 32'h2222_2222};
    vecs[7] = '{32'h0000_1008, 32'h0000_0000, 0, 1'b1, 32'h2222_2222};
    for (int v = 0; v < 8; v++) begin
      do_lookup($sformatf("vec%0d", v), vecs[v].addr, vecs[v].seed, vecs[v].ack_dly,
                0, 4'd0, 1'b0, vecs[v].exp_hit, vecs[v].exp_seed);
      m_update(vecs[v].addr, vecs[v].seed, vecs[v].exp_hit, 1'b0, 4'd0);
      chk_cnt($sformatf("vec%0d", v));
    end

    // Fill every index, then clear them all through the init stream.
    for (int i = 0; i < 16; i++)
      run_lookup($sformatf("fill%0d", i), 32'h0000_3000 + 32'(i * 4), 32'h5EED_0000 + 32'(i), 1, 0, 4'd0, 1'b0);
    run_lookup("fill hit", 32'h0000_3014, 32'h0, 0, 0, 4'd0, 1'b0);
    init_sweep();

    // Two misses then three hits; counters were cleared by the sweep.
    run_lookup("stat m0", 32'h0000_3000, 32'h0000_AAAA, 0, 0, 4'd0, 1'b0);
    run_lookup("stat m1", 32'h0000_3004, 32'h0000_BBBB, 1, 0, 4'd0, 1'b0);
    run_lookup("stat h0", 32'h0000_3000, 32'h0, 0, 0, 4'd0, 1'b0);
    run_lookup("stat h1", 32'h0000_3004, 32'h0, 0, 0, 4'd0, 1'b0);
    run_lookup("stat h2", 32'h0000_3000, 32'h0, 0, 0, 4'd0, 1'b0);
`ifdef SEED_CACHE_STATS_EN
    chk("stats hit_cnt=3",  32'(bus.hit_cnt),  32'd3);
    chk("stats miss_cnt=2", 32'(bus.miss_cnt), 32'd2);
`else
    chk("stats hit_cnt=0",  32'(bus.hit_cnt),  32'd0);
    chk("stats miss_cnt=0", 32'(bus.miss_cnt), 32'd0);
`endif
    for (int i = 2; i < 16; i++)
      run_lookup($sformatf("post sweep%0d", i), 32'h0000_3000 + 32'(i * 4), 32'h7000_0000 + 32'(i), 0, 0, 4'd0, 1'b0);
    init_pulse("init rise", 4'd0);
    run_lookup("idx0 cleared", 32'h0000_3000, 32'h0000_CCCC, 0, 0, 4'd0, 1'b0);
    run_lookup("idx2 kept",    32'h0000_3008, 32'h0, 0, 0, 4'd0, 1'b0);

    // Init during refill suppresses the fill; init during lookup downgrades a hit.
    run_lookup("stale refill", 32'h0000_5010, 32'h0000_D00D, 4, 3, 4'd9, 1'b0);
    run_lookup("stale retry",  32'h0000_5010, 32'h0000_E00E, 0, 0, 4'd0, 1'b0);
    run_lookup("lk fill",      32'h0000_6014, 32'h0000_F00F, 0, 0, 4'd0, 1'b0);
    run_lookup("lk downgrade", 32'h0000_6014, 32'h0000_1111, 1, 0, 4'd0, 1'b1);
    run_lookup("lk retry",     32'h0000_6014, 32'h0000_2222, 0, 0, 4'd0, 1'b0);

    // Reset while a refill is outstanding drops it; a late ack is ignored.
    bus.lk_addr  = 32'h0000_7018;
    bus.lk_valid = 1'b1;
    @(posedge clk); #1;
    bus.lk_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst-refill gen_req", 32'(bus.gen_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    chk("rst-refill gen_req drop", 32'(bus.gen_req), 32'd0);
    bus.gen_ack  = 1'b1;
    bus.gen_seed = 32'h0000_3333;
    @(posedge clk); #1;
    bus.gen_ack = 1'b0;
    chk("late ack rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("late ack lk_ready",  32'(bus.lk_ready),  32'd1);
    chk_cnt("rst-refill");
    run_lookup("after rst", 32'h0000_3008, 32'h0000_4444, 0, 0, 4'd0, 1'b0);

    // Randomized lookups over a small tag space to force hits, conflicts and clears.
    for (int r = 0; r < 150; r++) begin
      logic [31:0] a;
      int          dly, icyc;
      bit          ilk;
      a    = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      dly  = $urandom_range(0, 3);
      icyc = 0;
      ilk  = ($urandom_range(0, 19) == 0);
      if (dly > 0 && $urandom_range(0, 9) == 0) icyc = $urandom_range(1, dly);
      run_lookup($sformatf("rnd%0d", r), a, $urandom, dly, icyc, 4'($urandom_range(0, 15)), ilk);
      if ($urandom_range(0, 19) == 0) init_pulse($sformatf("rnd%0d clr", r), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/seed_cache_tag_ctrl.md
Name: seed_cache_tag_ctrl

Overview:
- Direct-mapped seed cache: holds a tag, a valid bit and a seed word per entry, and serves seed lookups from the crypto datapath.
- On a miss, fetches the seed from the seed generator over a req/ack handshake, then fills the entry.
- Consumes the clear-address stream and the busy flag from the seed-cache init sequencer, which fires on l.end. While that stream is active, every addressed valid bit is cleared and new lookups are blocked.

Parameters:
- ADDR_W, 32, lookup address width
- LS, 2, low address bits ignored (word granularity)
- INDEX_W, 4, index width; number of entries = 2^INDEX_W
- SEED_W, 32, seed data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready
- lk_addr  in  ADDR_W  lookup address
- rsp_valid  out  1  one-cycle response strobe
- rsp_hit  out  1  1 = served from cache, 0 = served by refill
- rsp_seed  out  SEED_W  response seed
- gen_req  out  1  refill request to seed generator
- gen_addr  out  ADDR_W  refill address (low LS bits zero)
- gen_ack  in  1  refill data valid
- gen_seed  in  SEED_W  refill seed
- init_active  in  1  init sequencer clearing
- init_addr  in  INDEX_W  index to clear this cycle
- hit_cnt  out  16  hit counter (see Optional Feature)
- miss_cnt  out  16  miss counter (see Optional Feature)

Behaviour:
- Address split:
  - idx = lk_addr[LS+INDEX_W-1:LS]
  - tag = lk_addr[ADDR_W-1:LS+INDEX_W]
  - Tag width = ADDR_W-LS-INDEX_W.
- Reset (synchronous):
  - state=IDLE; all valid bits=0.
  - rsp_valid=0, rsp_hit=0, rsp_seed=0, gen_req=0, gen_addr=0, counters=0.
  - Tag and seed arrays are not reset.
  - Reset mid-refill drops the request: gen_req=0 the next cycle, and a late gen_ack is ignored.
- States:
  - IDLE:
    - lk_ready = (state==IDLE) && !init_active.
    - On accept, register lk_addr and read the array entry; go to LOOKUP.
  - LOOKUP:
    - Compare the registered tag against stored valid && tag.
    - Hit: rsp_valid=1, rsp_hit=1, rsp_seed=stored seed in the next cycle; return to IDLE.
    - Miss: go to REFILL and set gen_req=1, gen_addr={addr[ADDR_W-1:LS], LS'b0} in the next cycle.
  - REFILL:
    - gen_req held high until the cycle gen_ack=1.
    - In that cycle, capture gen_seed and write tag/seed/valid=1 to the entry.
    - Next cycle: gen_req=0, rsp_valid=1, rsp_hit=0, rsp_seed=gen_seed; go to IDLE.
- Latency:
  - Hit: accept at T gives rsp_valid at T+2.
  - Miss: gen_req at T+2; gen_ack at cycle A gives rsp_valid at A+1.
- rsp_valid is a single-cycle pulse; there is no backpressure on the response.
- Invalidation:
  - While init_active=1, valid[init_addr] <= 0 every cycle, in any state.
  - A clear and a lookup read of the same index in one cycle: the read sees the old value. Cannot occur from IDLE because lk_ready=0 during init.
  - If init_active was seen high at any cycle during LOOKUP or REFILL, that refill's array write is suppressed (stale flag). The response is still returned with rsp_hit=0 and the gen_seed value.
  - If a refill write and a clear hit the same index in the same cycle, the clear wins (valid=0).
  - A hit detected in LOOKUP while init_active is high is downgraded to a miss and goes to REFILL, so no stale seed is returned.
- Valid bits are one flop per entry; tag/seed arrays may be distributed RAM with registered read.

Optional Feature:
- Macro: SEED_CACHE_STATS_EN.
- Defined:
  - hit_cnt increments on each rsp_valid with rsp_hit=1.
  - miss_cnt increments on each rsp_valid with rsp_hit=0.
  - Both are 16-bit and saturate at 16'hFFFF. Both clear on rst and on the rising edge of init_active.
- Undefined: hit_cnt=miss_cnt=0 constant, and no counter logic is generated.

Test Plan:
- Reset, then lookup 0x00001004:
  - Miss: gen_req=1, gen_addr=0x00001004 at T+2.
  - gen_ack with seed 0xA5A5A5A5 at A: rsp_valid, rsp_hit=0, seed 0xA5A5A5A5 at A+1.
- Repeat lookup 0x00001004: rsp_valid, rsp_hit=1, seed 0xA5A5A5A5 at T+2; gen_req stays 0.
- Lookup 0x00002004 (same idx=1, different tag): miss and refill with 0x12345678. Then 0x00001004 misses again (conflict eviction).
- Fill idx 0..15, then drive init_active 16 cycles with init_addr 15..0:
  - lk_ready=0 throughout.
  - Afterwards, every earlier address misses.
- Assert init_active for 3 cycles during REFILL before gen_ack:
  - Response has rsp_hit=0 with the gen_seed value.
  - The following lookup of the same address misses (write suppressed).
- With SEED_CACHE_STATS_EN, run 3 hits and 2 misses: hit_cnt=3, miss_cnt=2; a rising edge of init_active clears both. Without the macro, both read 0.
